// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch port and the data port.
// Data wins ties; a streak limiter hands the slot to fetch after MAX_DATA_STREAK data grants.
//
// state | meaning
// IDLE  | no access in flight; evaluates if_req/d_req
// ISSUE | mem_en strobe cycle for the registered owner
// WAIT  | LATENCY cycles counting down; captures mem_rdata on the last one
// RESP  | one-cycle ready pulse to the owner
module mem_port_arbiter #(
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD  = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] streak;
    logic       owner_d;
    logic       owner_we;
    logic       grant_d;

    // Fetch only displaces a pending data request once the streak has saturated.
    assign grant_d = d_req && !(if_req && (streak == STREAK_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            streak    <= '0;
            owner_d   <= 1'b0;
            owner_we  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d   <= 1'b1;
                        owner_we  <= d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!if_req)
                            streak <= '0;
                        else if (streak < STREAK_MAX)
                            streak <= streak + 4'd1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end else if (if_req) begin
                        owner_d   <= 1'b0;
                        owner_we  <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        streak    <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (owner_d) begin
                            if (!owner_we)
                                d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY 1 and 3) checked every cycle against
// a transaction-timeline model, plus directed literal checks and randomized traffic.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic [1:0]  reset;
    logic [1:0]  if_req;
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic [1:0]  if_ready;
    logic [1:0]  d_req;
    logic [1:0]  d_we;
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] d_rdata   [2];
    logic [1:0]  d_ready;
    logic [1:0]  mem_en;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  busy;

    mem_port_arbiter #(.LATENCY(1), .MAX_DATA_STREAK(MAXS)) dut0 (
        .clk(clk), .reset(reset[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ready(d_ready[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.LATENCY(3), .MAX_DATA_STREAK(MAXS)) dut1 (
        .clk(clk), .reset(reset[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ready(d_ready[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit log_on  = 1'b0;
    string m_order = "";
    string d_order = "";

    // Model: each transaction is a timeline counted in edges since its grant edge.
    bit          m_act    [2];
    int          m_k      [2];
    bit          m_own_d  [2];
    bit          m_we     [2];
    int          m_streak [2];
    logic        e_mem_en [2];
    logic        e_mem_we [2];
    logic [31:0] e_mem_addr  [2];
    logic [31:0] e_mem_wdata [2];
    logic        e_busy   [2];
    logic        e_if_ready [2];
    logic        e_d_ready  [2];
    logic [31:0] e_if_rdata [2];
    logic [31:0] e_d_rdata  [2];

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int    lat;
        bit    dw;
        string g;
        lat = (i == 0) ? 1 : 3;
        if (reset[i]) begin
            m_act[i] = 0; m_k[i] = 0; m_streak[i] = 0;
            e_mem_en[i] = 0; e_mem_we[i] = 0; e_mem_addr[i] = 0; e_mem_wdata[i] = 0;
            e_busy[i] = 0; e_if_ready[i] = 0; e_d_ready[i] = 0;
            e_if_rdata[i] = 0; e_d_rdata[i] = 0;
        end else if (!m_act[i]) begin
            if (if_req[i] || d_req[i]) begin
                dw = d_req[i] && !(if_req[i] && m_streak[i] == MAXS);
                m_act[i] = 1; m_k[i] = 0; m_own_d[i] = dw; m_we[i] = dw && d_we[i];
                e_mem_en[i] = 1; e_mem_we[i] = m_we[i]; e_busy[i] = 1;
                if (dw) begin
                    e_mem_addr[i]  = d_addr[i];
                    e_mem_wdata[i] = d_wdata[i];
                    if (!if_req[i]) m_streak[i] = 0;
                    else m_streak[i] = (m_streak[i] < MAXS) ? m_streak[i] + 1 : MAXS;
                end else begin
                    e_mem_addr[i] = if_addr[i];
                    m_streak[i] = 0;
                end
                if (log_on && i == 0) begin
                    g = dw ? "D" : "I";
                    m_order = {m_order, g};
                end
            end
        end else begin
            m_k[i] = m_k[i] + 1;
            e_mem_en[i] = 0; e_mem_we[i] = 0;
            if (m_k[i] == lat + 1) begin
                if (m_own_d[i]) begin
                    if (!m_we[i]) e_d_rdata[i] = mem_rdata[i];
                    e_d_ready[i] = 1;
                end else begin
                    e_if_rdata[i] = mem_rdata[i];
                    e_if_ready[i] = 1;
                end
            end else if (m_k[i] == lat + 2) begin
                e_if_ready[i] = 0; e_d_ready[i] = 0; e_busy[i] = 0; m_act[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("mem_en",   i, {31'b0, mem_en[i]},   {31'b0, e_mem_en[i]});
                chk("mem_we",   i, {31'b0, mem_we[i]},   {31'b0, e_mem_we[i]});
                chk("mem_addr", i, mem_addr[i],          e_mem_addr[i]);
                if (e_mem_en[i] && e_mem_we[i])
                    chk("mem_wdata", i, mem_wdata[i], e_mem_wdata[i]);
                chk("busy",     i, {31'b0, busy[i]},     {31'b0, e_busy[i]});
                chk("if_ready", i, {31'b0, if_ready[i]}, {31'b0, e_if_ready[i]});
                chk("d_ready",  i, {31'b0, d_ready[i]},  {31'b0, e_d_ready[i]});
                chk("if_rdata", i, if_rdata[i],          e_if_rdata[i]);
                chk("d_rdata",  i, d_rdata[i],           e_d_rdata[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    bit saw_ifr [2];
    bit saw_dr  [2];
    bit saw_if;

    initial begin
        reset = 2'b11; if_req = 2'b11; d_req = 2'b11; d_we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if_addr[i] = 32'h4; d_addr[i] = 32'h8; d_wdata[i] = 32'h0; mem_rdata[i] = 32'h0;
            saw_ifr[i] = 0; saw_dr[i] = 0;
        end

        // reset held two cycles with both requests high
        tick();
        chk_on = 1'b1;
        for (int c = 0; c < 2; c++) begin
            samp();
            chk("rst_mem_en", 0, {31'b0, mem_en[0]}, 32'h0);
            chk("rst_busy",   0, {31'b0, busy[0]},   32'h0);
            chk("rst_busy",   1, {31'b0, busy[1]},   32'h0);
            chk("rst_ready",  0, {31'b0, if_ready[0] | d_ready[0]}, 32'h0);
            if (c == 0) tick();
        end
        tick(); reset = 2'b00; if_req = 2'b00; d_req = 2'b00;

        // single fetch, LATENCY=1
        tick(); if_req[0] = 1; if_addr[0] = 32'h40;
        samp(); chk("t2_busy_t0", 0, {31'b0, busy[0]}, 32'h0);
        tick(); samp();
        chk("t2_mem_en_t1", 0, {31'b0, mem_en[0]}, 32'h1);
        chk("t2_mem_addr_t1", 0, mem_addr[0], 32'h40);
        tick(); mem_rdata[0] = 32'hDEADBEEF;
        tick(); samp();
        chk("t2_if_ready_t3", 0, {31'b0, if_ready[0]}, 32'h1);
        chk("t2_if_rdata_t3", 0, if_rdata[0], 32'hDEADBEEF);
        chk("t2_model_rdata", 0, e_if_rdata[0], 32'hDEADBEEF);
        tick(); if_req[0] = 0;

        // simultaneous fetch and load: data first
        tick(); if_req[0] = 1; if_addr[0] = 32'h200; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h100;
        tick(); samp();
        chk("t3_mem_en_t1", 0, {31'b0, mem_en[0]}, 32'h1);
        chk("t3_mem_addr_t1", 0, mem_addr[0], 32'h100);
        tick(); mem_rdata[0] = 32'hA5A50100;
        tick(); samp();
        chk("t3_d_ready_t3", 0, {31'b0, d_ready[0]}, 32'h1);
        chk("t3_d_rdata_t3", 0, d_rdata[0], 32'hA5A50100);
        chk("t3_if_ready_t3", 0, {31'b0, if_ready[0]}, 32'h0);
        tick(); d_req[0] = 0; mem_rdata[0] = 32'h11112222;
        tick(); samp();
        chk("t3_mem_en_t5", 0, {31'b0, mem_en[0]}, 32'h1);
        chk("t3_mem_addr_t5", 0, mem_addr[0], 32'h200);
        tick(); mem_rdata[0] = 32'h600DF00D;
        tick(); samp();
        chk("t3_if_ready_t7", 0, {31'b0, if_ready[0]}, 32'h1);
        chk("t3_if_rdata_t7", 0, if_rdata[0], 32'h600DF00D);
        tick(); if_req[0] = 0;

        // store: d_rdata must keep the previous load value
        tick(); d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h10; d_wdata[0] = 32'h12345678;
        mem_rdata[0] = 32'hFFFFFFFF;
        tick(); samp();
        chk("t4_mem_en", 0, {31'b0, mem_en[0]}, 32'h1);
        chk("t4_mem_we", 0, {31'b0, mem_we[0]}, 32'h1);
        chk("t4_mem_wdata", 0, mem_wdata[0], 32'h12345678);
        tick(); samp();
        chk("t4_mem_we_off", 0, {31'b0, mem_we[0]}, 32'h0);
        tick(); samp();
        chk("t4_d_ready", 0, {31'b0, d_ready[0]}, 32'h1);
        chk("t4_d_rdata_kept", 0, d_rdata[0], 32'hA5A50100);
        tick(); d_req[0] = 0; d_we[0] = 0;

        // streak limiter
        tick(); if_req[0] = 1; if_addr[0] = 32'h300; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h400;
        log_on = 1; saw_if = 0;
        for (int c = 0; c < 80; c++) begin
            samp();
            if (mem_en[0]) d_order = {d_order, (mem_addr[0] == 32'h300) ? "I" : "D"};
            if (if_ready[0]) saw_if = 1;
            if (d_order.len() >= 7) break;
            tick();
            if (saw_if) if_req[0] = 0;
        end
        log_on = 0;
        n_tests++;
        if (d_order != "DDDDIDD") begin
            n_fail++;
            $display("FAIL t5_grant_order: got %s expected DDDDIDD", d_order);
        end
        n_tests++;
        if (m_order != "DDDDIDD") begin
            n_fail++;
            $display("FAIL t5_model_order: got %s expected DDDDIDD", m_order);
        end
        tick(); d_req[0] = 0; if_req[0] = 0;
        for (int c = 0; c < 8; c++) tick();

        // LATENCY=3: reset in the second WAIT cycle abandons the access
        tick(); d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h500;
        tick(); tick(); tick(); reset[1] = 1;
        tick(); reset[1] = 0; d_addr[1] = 32'h600;
        samp();
        chk("t6_busy_after_rst", 1, {31'b0, busy[1]}, 32'h0);
        chk("t6_no_ready", 1, {31'b0, d_ready[1]}, 32'h0);
        tick(); samp();
        chk("t6_no_stale_ready", 1, {31'b0, d_ready[1]}, 32'h0);
        chk("t6_mem_addr", 1, mem_addr[1], 32'h600);
        tick(); tick(); tick(); mem_rdata[1] = 32'hC0FFEE00;
        tick(); samp();
        chk("t6_d_ready_5cyc", 1, {31'b0, d_ready[1]}, 32'h1);
        chk("t6_d_rdata", 1, d_rdata[1], 32'hC0FFEE00);
        tick(); d_req[1] = 0;
        tick();

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                reset[i] = ($urandom_range(199) == 0);
                mem_rdata[i] = $urandom;
                if (if_req[i] && saw_ifr[i]) if_req[i] = 0;
                if (!if_req[i] && $urandom_range(2) != 0) begin
                    if_req[i] = 1; if_addr[i] = $urandom;
                end
                if (d_req[i] && saw_dr[i]) d_req[i] = 0;
                if (!d_req[i] && $urandom_range(2) != 0) begin
                    d_req[i] = 1; d_we[i] = $urandom_range(1); d_addr[i] = $urandom; d_wdata[i] = $urandom;
                end
            end
            samp();
            for (int i = 0; i < 2; i++) begin
                saw_ifr[i] = if_ready[i];
                saw_dr[i]  = d_ready[i];
            end
        end
        tick(); reset = 2'b00; if_req = 2'b00; d_req = 2'b00;
        for (int c = 0; c < 10; c++) tick();
        samp();
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
